rvv_backend_rob_byp_buffer: RTL

In-order result buffer on the producer side of the dispatch bypass path. It allocates one entry per dispatched uop and captures the writeback data for that entry. It presents every completed entry to dispatch as age-ordered bypass records: write data, per-byte type, and inactive/tail fill flags. It also retires entries in order toward the VRF write port.

---
 rtl/rvv_backend_rob_byp_buffer.sv | 126 ++++++++++++
 1 files changed

// File: rtl/rvv_backend_rob_byp_buffer.sv
// In-order result buffer feeding the dispatch bypass path: allocates per uop,
// captures writeback data, exposes age-ordered bypass records and retires in order.
module rvv_backend_rob_byp_buffer #(
  parameter int DEPTH = 8,
  parameter int VLENB = 16,
  parameter int VLEN  = 8*VLENB,
  parameter int TAGW  = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      alloc_valid,
  output logic                      alloc_ready,
  input  logic [4:0]                alloc_vd,
  input  logic [2*VLENB-1:0]        alloc_byte_type,
  input  logic                      alloc_inactive_one,
  input  logic                      alloc_tail_one,
  output logic [TAGW-1:0]           alloc_tag,
  input  logic                      wb_valid,
  input  logic [TAGW-1:0]           wb_tag,
  input  logic [VLEN-1:0]           wb_data,
  output logic                      wb_err,
  output logic                      retire_valid,
  input  logic                      retire_ready,
  output logic [4:0]                retire_vd,
  output logic [VLEN-1:0]           retire_data,
  output logic [2*VLENB-1:0]        retire_byte_type,
  output logic [DEPTH-1:0]          byp_valid,
  output logic [5*DEPTH-1:0]        byp_vd,
  output logic [VLEN*DEPTH-1:0]     byp_w_data,
  output logic [2*VLENB*DEPTH-1:0]  byp_byte_type,
  output logic [DEPTH-1:0]          byp_inactive_one,
  output logic [DEPTH-1:0]          byp_tail_one
);

  localparam logic [TAGW:0] FULL_CNT = (TAGW+1)'(DEPTH);

  logic [TAGW-1:0]    wr_ptr;
  logic [TAGW-1:0]    rd_ptr;
  logic [TAGW:0]      count;
  logic [DEPTH-1:0]   valid_q;
  logic [DEPTH-1:0]   done_q;
  logic [DEPTH-1:0]   ione_q;
  logic [DEPTH-1:0]   tone_q;
  logic [4:0]         vd_q   [DEPTH];
  logic [2*VLENB-1:0] bt_q   [DEPTH];
  logic [VLEN-1:0]    data_q [DEPTH];

  logic alloc_fire;
  logic retire_fire;
  logic wb_ok;

  // A retire that frees a slot does not make the same-cycle alloc legal.
  assign alloc_ready  = (count != FULL_CNT) && !flush;
  assign alloc_fire   = alloc_valid & alloc_ready;
  assign retire_valid = (count != '0) & valid_q[rd_ptr] & done_q[rd_ptr];
  assign retire_fire  = retire_valid & retire_ready & ~flush;
  assign wb_ok        = valid_q[wb_tag] & ~done_q[wb_tag];
  assign alloc_tag    = wr_ptr;

  assign retire_vd        = vd_q[rd_ptr];
  assign retire_data      = data_q[rd_ptr];
  assign retire_byte_type = bt_q[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      valid_q <= '0;
      done_q  <= '0;
      ione_q  <= '0;
      tone_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        vd_q[i]   <= '0;
        bt_q[i]   <= '0;
        data_q[i] <= '0;
      end
    end else begin
      if (wb_valid && wb_ok) begin
        data_q[wb_tag] <= wb_data;
        done_q[wb_tag] <= 1'b1;
      end
      if (retire_fire) begin
        valid_q[rd_ptr] <= 1'b0;
        rd_ptr          <= rd_ptr + TAGW'(1);
      end
      if (alloc_fire) begin
        valid_q[wr_ptr] <= 1'b1;
        done_q[wr_ptr]  <= 1'b0;
        vd_q[wr_ptr]    <= alloc_vd;
        bt_q[wr_ptr]    <= alloc_byte_type;
        ione_q[wr_ptr]  <= alloc_inactive_one;
        tone_q[wr_ptr]  <= alloc_tail_one;
        data_q[wr_ptr]  <= '0;
        wr_ptr          <= wr_ptr + TAGW'(1);
      end
      case ({alloc_fire, retire_fire})
        2'b10:   count <= count + (TAGW+1)'(1);
        2'b01:   count <= count - (TAGW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky error survives flush; only reset clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_err <= 1'b0;
    end else if (!flush && wb_valid && !wb_ok) begin
      wb_err <= 1'b1;
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_byp
    logic [TAGW-1:0] slot;
    assign slot                                  = rd_ptr + TAGW'(k);
    assign byp_valid[k]                          = valid_q[slot] & done_q[slot];
    assign byp_vd[5*k +: 5]                      = vd_q[slot];
    assign byp_w_data[VLEN*k +: VLEN]            = data_q[slot];
    assign byp_byte_type[2*VLENB*k +: 2*VLENB]   = bt_q[slot];
    assign byp_inactive_one[k]                   = ione_q[slot];
    assign byp_tail_one[k]                       = tone_q[slot];
  end

endmodule
